// File: rtl/prefetch_pkg.sv
// Shared widths, reset fetch address and the queued fetch entry type for the prefetch stage.
package prefetch_pkg;

   localparam int INST_W = 32;
   localparam int ADDR_W = 32;
   localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam logic [INST_W-1:0] NOP = 32'h0000_0000;

   typedef struct packed {
      logic [ADDR_W-1:0] pc;
      logic [INST_W-1:0] inst;
   } fetch_entry_t;

endpackage

// File: rtl/prefetch_fifo.sv
// Small power-of-two FIFO with synchronous active-low clear and a flush input;
// the head entry is always visible on rd_data.
module prefetch_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rd_data,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;

   always_ff @(posedge clk) begin
      if (!rst || flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
         count <= count + CNT_W'(push) - CNT_W'(pop);
      end
   end

   // Storage needs no reset; only slots behind the write pointer are ever read.
   always_ff @(posedge clk) begin
      if (rst && !flush && push) mem[wr_ptr] <= wr_data;
   end

   assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/prefetch_buffer.sv
// Instruction prefetch stage: credit-limited sequential fetch, in-order response queue,
// redirect flush with stale-response discard. Optional PREFETCH_BYPASS_EN forwards responses straight to decode.
module prefetch_buffer
   import prefetch_pkg::*;
#(
   parameter int unsigned       DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              imem_req_valid,
   input  logic              imem_req_ready,
   output logic [ADDR_W-1:0] imem_req_addr,
   input  logic              imem_resp_valid,
   input  logic [INST_W-1:0] imem_resp_data,
   output logic              inst_valid,
   input  logic              inst_ready,
   output logic [INST_W-1:0] inst,
   output logic [ADDR_W-1:0] inst_pc
);

   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam int ENTRY_W = $bits(fetch_entry_t);
   localparam logic [CNT_W:0]   FULL_LEVEL = (CNT_W + 1)'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [ADDR_W-1:0] fetch_pc;
   logic [ADDR_W-1:0] redirect_aligned;
   logic [ADDR_W-1:0] pc_head;
   logic [CNT_W-1:0]  outstanding;
   logic [CNT_W-1:0]  discard;
   logic [CNT_W-1:0]  q_count;
   logic [CNT_W-1:0]  pc_count;
   logic [CNT_W:0]    credit_used;
   fetch_entry_t      q_head;
   fetch_entry_t      push_entry;
   fetch_entry_t      shown;
   fetch_entry_t      last_shown;
   logic              req_fire;
   logic              resp_live;
   logic              q_empty;
   logic              q_push;
   logic              q_pop;
   logic              pc_pop;
   logic              bypass_hit;
   logic              bypass_take;

   assign redirect_aligned = redirect_pc & ~ADDR_W'(3);
   assign credit_used      = {1'b0, q_count} + {1'b0, outstanding};
   assign q_empty          = (q_count == '0);

   // Queued entries plus in-flight requests never exceed DEPTH, so the queue cannot overflow.
   assign imem_req_valid = rst && !redirect && (credit_used < FULL_LEVEL);
   assign imem_req_addr  = fetch_pc;
   assign req_fire       = imem_req_valid && imem_req_ready;

   assign resp_live  = imem_resp_valid && !redirect && (discard == '0);
   assign push_entry = '{pc: pc_head, inst: imem_resp_data};
   assign pc_pop     = resp_live && (pc_count != '0);

`ifdef PREFETCH_BYPASS_EN
   assign bypass_hit = resp_live && q_empty;
`else
   assign bypass_hit = 1'b0;
`endif
   assign bypass_take = bypass_hit && inst_ready;
   assign q_push      = resp_live && !bypass_take;

   assign inst_valid = rst && !redirect && (!q_empty || bypass_hit);
   assign q_pop      = inst_valid && inst_ready && !q_empty;

   // An empty queue keeps presenting whatever decode saw last.
   assign shown   = bypass_hit ? push_entry : (!q_empty ? q_head : last_shown);
   assign inst    = rst ? shown.inst : '0;
   assign inst_pc = rst ? shown.pc : '0;

   always_ff @(posedge clk) begin
      if (!rst) begin
         fetch_pc    <= RESET_PC;
         outstanding <= '0;
         discard     <= '0;
         last_shown  <= '{pc: '0, inst: NOP};
      end else begin
         last_shown <= shown;
         if (redirect) begin
            fetch_pc    <= redirect_aligned;
            outstanding <= outstanding - CNT_W'(imem_resp_valid);
            discard     <= outstanding - CNT_W'(imem_resp_valid);
         end else begin
            if (req_fire) fetch_pc <= fetch_pc + 32'd4;
            outstanding <= outstanding + CNT_W'(req_fire) - CNT_W'(imem_resp_valid);
            if (imem_resp_valid && (discard != '0)) discard <= discard - CNT_ONE;
         end
      end
   end

   prefetch_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ENTRY_W)
   ) u_entry_q (
      .clk     (clk),
      .rst     (rst),
      .flush   (redirect),
      .push    (q_push),
      .wr_data (push_entry),
      .pop     (q_pop),
      .rd_data (q_head),
      .count   (q_count)
   );

   // Addresses of live (non-discarded) requests, matched to responses in order.
   prefetch_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ADDR_W)
   ) u_pc_q (
      .clk     (clk),
      .rst     (rst),
      .flush   (redirect),
      .push    (req_fire),
      .wr_data (fetch_pc),
      .pop     (pc_pop),
      .rd_data (pc_head),
      .count   (pc_count)
   );

endmodule

// File: tb/tb_prefetch_buffer.sv
// Scoreboard bench for prefetch_buffer: an in-order memory model answers requests and
// every PC accepted since the last redirect must reach decode in order with its memory word.
module tb_prefetch_buffer;

`ifdef PREFETCH_BYPASS_EN
   localparam logic BYPASS = 1'b1;
`else
   localparam logic BYPASS = 1'b0;
`endif

   logic        clk;
   logic        rst;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst;
   logic [31:0] inst_pc;

   int          tests_run = 0;
   int          tests_failed = 0;
   int          cyc = 0;
   int          lat = 1;
   int          accepts;
   logic [31:0] exp_q[$];
   logic [31:0] mem_addr_q[$];
   int          mem_due_q[$];
   logic [31:0] exp_fetch_pc;
   logic        last_req_valid;
   logic        last_accept;
   logic        last_resp;
   logic        last_inst_valid;
   logic [31:0] last_req_addr;

   prefetch_buffer #(
      .DEPTH    (4),
      .RESET_PC (32'h0000_0000)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .redirect        (redirect),
      .redirect_pc     (redirect_pc),
      .imem_req_valid  (imem_req_valid),
      .imem_req_ready  (imem_req_ready),
      .imem_req_addr   (imem_req_addr),
      .imem_resp_valid (imem_resp_valid),
      .imem_resp_data  (imem_resp_data),
      .inst_valid      (inst_valid),
      .inst_ready      (inst_ready),
      .inst            (inst),
      .inst_pc         (inst_pc)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("[TB] FAIL timeout: simulation did not finish (got running, required finished)");
      $fatal(1, "[TB] timeout");
   end

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
   endfunction

   task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      tests_run++;
      if (observed !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %h, required %h (cycle %0d)", tag, observed, expected, cyc);
      end
   endtask

   // One clock: present the memory response, sample outputs, update models, advance.
   task automatic tick();
      logic [31:0] e;
      if (mem_addr_q.size() != 0 && mem_due_q[0] <= cyc) begin
         imem_resp_valid = 1'b1;
         imem_resp_data  = mem_word(mem_addr_q[0]);
      end else begin
         imem_resp_valid = 1'b0;
         imem_resp_data  = $urandom;
      end
      #1;
      last_req_valid  = imem_req_valid;
      last_req_addr   = imem_req_addr;
      last_accept     = imem_req_valid && imem_req_ready;
      last_resp       = imem_resp_valid;
      last_inst_valid = inst_valid;
      if (rst) begin
         if (inst_valid && inst_ready) begin
            if (exp_q.size() == 0) begin
               check_output("sb_underflow", exp_q.size(), 1);
            end else begin
               e = exp_q.pop_front();
               check_output("inst_pc", inst_pc, e);
               check_output("inst", inst, mem_word(e));
            end
         end
         if (redirect) begin
            check_output("redir_inst_valid", inst_valid, 0);
            check_output("redir_req_valid", imem_req_valid, 0);
            exp_q.delete();
            exp_fetch_pc = redirect_pc & 32'hFFFF_FFFC;
         end else if (last_accept) begin
            check_output("req_addr", imem_req_addr, exp_fetch_pc);
            exp_q.push_back(imem_req_addr);
            exp_fetch_pc = exp_fetch_pc + 32'd4;
         end
      end
      if (imem_resp_valid) begin
         void'(mem_addr_q.pop_front());
         void'(mem_due_q.pop_front());
      end
      if (last_accept) begin
         mem_addr_q.push_back(imem_req_addr);
         mem_due_q.push_back(cyc + lat);
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic apply_stimulus(input logic rdr, input logic [31:0] rpc, input logic req_rdy, input logic in_rdy);
      redirect       = rdr;
      redirect_pc    = rpc;
      imem_req_ready = req_rdy;
      inst_ready     = in_rdy;
      tick();
   endtask

   task automatic drain(input string tag);
      int n;
      n = 0;
      while ((mem_addr_q.size() != 0 || exp_q.size() != 0) && n < 60) begin
         apply_stimulus(1'b0, 32'h0, 1'b0, 1'b1);
         n++;
      end
      check_output({tag, "_left"}, exp_q.size(), 0);
      apply_stimulus(1'b0, 32'h0, 1'b0, 1'b1);
      check_output({tag, "_inst_valid"}, last_inst_valid, 0);
   endtask

   initial begin
      rst            = 1'b0;
      redirect       = 1'b0;
      redirect_pc    = 32'h0;
      imem_req_ready = 1'b0;
      inst_ready     = 1'b0;
      imem_resp_valid = 1'b0;
      imem_resp_data  = 32'h0;
      exp_fetch_pc   = 32'h0000_0000;

      // Reset state
      for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 32'h0, 1'b1, 1'b1);
      check_output("rst_req_valid", last_req_valid, 0);
      check_output("rst_inst_valid", last_inst_valid, 0);
      check_output("rst_inst", inst, 32'h0);
      check_output("rst_inst_pc", inst_pc, 32'h0);

      // Streaming with 1-cycle memory
      rst = 1'b1;
      apply_stimulus(1'b0, 32'h0, 1'b1, 1'b1);
      check_output("first_req_valid", last_req_valid, 1);
      check_output("first_req_addr", last_req_addr, 32'h0);
      for (int i = 0; i < 12; i++) apply_stimulus(1'b0, 32'h0, 1'b1, 1'b1);
      drain("stream");

      // Fill to DEPTH with decode stalled, then one pop frees one credit
      accepts = 0;
      for (int i = 0; i < 10; i++) begin
         apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0);
         accepts += int'(last_accept);
      end
      check_output("fill_accepts", accepts, 4);
      check_output("fill_req_valid", last_req_valid, 0);
      apply_stimulus(1'b0, 32'h0, 1'b1, 1'b1);
      check_output("pop_cycle_req", last_req_valid, 0);
      apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0);
      check_output("refill_accept", last_accept, 1);
      apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0);
      check_output("refill_full", last_req_valid, 0);
      drain("fill");

      // One queued entry, 3 outstanding, redirect to 0x43
      lat = 1;
      apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0);
      lat = 6;
      accepts = int'(last_accept);
      for (int i = 0; i < 3; i++) begin
         apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0);
         accepts += int'(last_accept);
      end
      check_output("pre_redir_accepts", accepts, 4);
      lat = 2;
      apply_stimulus(1'b1, 32'h0000_0043, 1'b1, 1'b0);
      apply_stimulus(1'b0, 32'h0, 1'b1, 1'b1);
      check_output("redir_next_req", last_req_valid, 1);
      check_output("redir_next_addr", last_req_addr, 32'h0000_0040);
      for (int i = 0; i < 10; i++) apply_stimulus(1'b0, 32'h0, 1'b1, 1'b1);
      drain("redir");

      // Redirect in the same cycle as a response, 2 outstanding
      lat = 2;
      apply_stimulus(1'b0, 32'h0, 1'b1, 1'b1);
      apply_stimulus(1'b0, 32'h0, 1'b1, 1'b1);
      apply_stimulus(1'b1, 32'h0000_0100, 1'b0, 1'b1);
      check_output("redir_resp_same", last_resp, 1);
      for (int i = 0; i < 8; i++) apply_stimulus(1'b0, 32'h0, 1'b1, 1'b1);
      drain("redir_resp");

      // Memory stalls: address held, fetch_pc frozen
      for (int i = 0; i < 5; i++) begin
         apply_stimulus(1'b0, 32'h0, 1'b0, 1'b1);
         check_output("hold_valid", last_req_valid, 1);
         check_output("hold_addr", last_req_addr, exp_fetch_pc);
      end
      apply_stimulus(1'b0, 32'h0, 1'b1, 1'b1);
      check_output("hold_release", last_accept, 1);
      drain("hold");

      // Response-to-decode latency on an empty queue
      lat = 1;
      apply_stimulus(1'b0, 32'h0, 1'b1, 1'b1);
      apply_stimulus(1'b0, 32'h0, 1'b0, 1'b1);
      check_output("lat_resp", last_resp, 1);
      check_output("lat_same_cycle", last_inst_valid, BYPASS);
      apply_stimulus(1'b0, 32'h0, 1'b0, 1'b1);
      check_output("lat_next_cycle", last_inst_valid, !BYPASS);
      drain("latency");

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/prefetch_buffer.md
# prefetch_buffer

Instruction prefetch stage sitting between the instruction memory and the decode stage. It generates sequential fetch addresses, issues them to a multi-cycle instruction memory over a valid/ready request port, and collects in-order responses into a small queue. Decode pops instruction/PC pairs through a valid/ready handshake. A taken branch or jump from execute redirects the stream, flushes the queue and discards stale in-flight responses.

## Interface
- DEPTH, 4, queue entries and the maximum of entries plus outstanding requests; power of two, ≥2
- RESET_PC, 32'h0000_0000, first fetch address after reset
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-low reset
- redirect  in  1  taken branch/jump this cycle
- redirect_pc  in  32  new fetch address; bits [1:0] ignored, forced to 0
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts the request
- imem_req_addr  out  32  fetch byte address, word aligned
- imem_resp_valid  in  1  response valid; in order, at least 1 cycle after acceptance
- imem_resp_data  in  32  instruction word
- inst_valid  out  1  head entry available to decode
- inst_ready  in  1  decode consumes the head entry
- inst  out  32  head instruction
- inst_pc  out  32  PC of the head instruction

## Operation
- Registers: fetch_pc, outstanding count (0..DEPTH), discard count (0..DEPTH), queue of {pc, inst} with read/write pointers modulo DEPTH and an occupancy count.
- Request: imem_req_valid = !redirect && (occupancy + outstanding < DEPTH); imem_req_addr = fetch_pc. On acceptance, fetch_pc += 4 (wraps modulo 2^32), outstanding += 1, and the address is stored in an in-flight PC FIFO of DEPTH entries.
- Response: outstanding −= 1. If discard > 0: discard −= 1 and drop. Otherwise push {pc from in-flight FIFO, data}.
- Pop: on inst_valid && inst_ready, advance the read pointer. Push and pop in the same cycle leave occupancy unchanged. The credit rule makes overflow impossible.
- Redirect has priority over everything else:
  - Queue emptied.
  - discard = outstanding, minus 1 if a response arrives the same cycle; that response is dropped.
  - Pending in-flight PCs cleared.
  - fetch_pc = {redirect_pc[31:2], 2'b00}.
  - No request is issued and inst_valid is forced to 0 in that cycle.
- Requests may be withdrawn only in a redirect cycle. Otherwise, once imem_req_valid is asserted, imem_req_addr is held until accepted.
- Requests issue while discard > 0. The credit rule counts discarding requests as outstanding.

## Timing
- During reset:
  - Outputs: imem_req_valid=0, inst_valid=0, inst=0, inst_pc=0.
  - Internal state: fetch_pc=RESET_PC, all counts and pointers 0.
- First request in the first cycle with rst=1.
- Response to inst_valid latency: 1 cycle when registered; see Configuration for 0.
- Redirect to the first request at the new address: 1 cycle (request in the cycle after redirect).
- Reset asserted mid-operation: all state returns to reset values on that edge. Responses arriving afterwards to pre-reset requests are outside this block's contract; memory is reset with it.
- Full: occupancy + outstanding = DEPTH deasserts imem_req_valid. A pop in a cycle re-enables the request in the next cycle.
- Empty: inst_valid=0, and inst/inst_pc hold their last values.

## Configuration
- PREFETCH_BYPASS_EN defined: when the queue is empty, discard = 0 and a valid response arrives without redirect, the response drives inst/inst_pc combinationally with inst_valid=1. If inst_ready is also 1, it is consumed without a push (0-cycle latency). Otherwise it is pushed.
- PREFETCH_BYPASS_EN undefined: every response is pushed; inst_valid rises the cycle after the response.

## Structure
- Package prefetch_pkg:
  - INST_W=32, ADDR_W=32, RESET_PC default
  - NOP constant 32'h0000_0000
  - Typedef fetch_entry_t {pc, inst}
- One sub-module, prefetch_fifo:
  - Parameterised DEPTH/width, synchronous active-low clear plus flush input.
  - Instantiated twice: the entry queue, and the in-flight PC FIFO.

## Test plan
- Reset release, memory with 1-cycle response latency, inst_ready=1: requests at 0x0, 0x4, 0x8…; inst_pc matches, inst equals the memory words in order.
- inst_ready=0, DEPTH=4: exactly 4 requests are accepted, then imem_req_valid stays 0. One pop, then exactly one further request in the next cycle.
- 3 outstanding, redirect to 0x40 (redirect_pc=0x43 also gives 0x40): inst_valid=0 in the redirect cycle, the 3 late responses are dropped, the first popped inst_pc is 0x40.
- Redirect in the same cycle as a response, 2 outstanding before it: both dropped, no stale entry reaches decode.
- imem_req_ready held low 5 cycles: imem_req_addr is stable throughout, fetch_pc does not advance.
- With PREFETCH_BYPASS_EN, empty queue, response plus inst_ready=1: inst_valid is seen in the same cycle. Without it, inst_valid is seen one cycle later.
